// File: rtl/dram_refresh_scheduler_if.sv
// Refresh scheduler <-> DRAM command controller handshake bundle.
// master: the scheduler side; slave: the command controller side.
interface dram_refresh_scheduler_if;
    logic       init_done;
    logic       bank_idle;
    logic       ref_ack;
    logic       ref_req;
    logic       ref_urgent;
    logic       ref_busy;
    logic [3:0] pending_cnt;
    logic       overflow_err;

    modport master (
        input  init_done,
        input  bank_idle,
        input  ref_ack,
        output ref_req,
        output ref_urgent,
        output ref_busy,
        output pending_cnt,
        output overflow_err
    );

    modport slave (
        output init_done,
        output bank_idle,
        output ref_ack,
        input  ref_req,
        input  ref_urgent,
        input  ref_busy,
        input  pending_cnt,
        input  overflow_err
    );
endinterface

// File: rtl/dram_refresh_scheduler.sv
// tREFI interval tracking, postponed-refresh debt and tRFC blackout for the DRAM command FSM.
// Optional feature macro: DRAM_REFRESH_POSTPONE_EN (postponement up to MAX_POSTPONE refreshes).
module dram_refresh_scheduler #(
    parameter int unsigned TREFI        = 250,
    parameter int unsigned TRFC         = 172,
    parameter int unsigned MAX_POSTPONE = 8
) (
    input logic                      CLK,
    input logic                      nRST,
    dram_refresh_scheduler_if.master bus
);

`ifdef DRAM_REFRESH_POSTPONE_EN
    localparam int unsigned MaxPostpone = MAX_POSTPONE;
`else
    // Without postponement every owed refresh is urgent and the debt cap is one.
    localparam int unsigned MaxPostpone = MAX_POSTPONE * 0;
`endif
    localparam int unsigned Cap  = MaxPostpone + 1;
    localparam int unsigned IntW = (TREFI > 1) ? $clog2(TREFI) : 1;
    localparam int unsigned RfcW = (TRFC > 1) ? $clog2(TRFC) : 1;

    localparam logic [IntW-1:0] IntLast = IntW'(TREFI - 1);
    localparam logic [RfcW-1:0] RfcLast = RfcW'(TRFC - 1);
    localparam logic [3:0]      CapCnt  = 4'(Cap);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRfc
    } state_e;

    state_e          state_q, state_d;
    logic [IntW-1:0] int_cnt_q, int_cnt_d;
    logic [RfcW-1:0] rfc_cnt_q, rfc_cnt_d;
    logic [3:0]      pending_q, pending_d;
    logic            overflow_q, overflow_d;
    logic            tick;
    logic            at_limit;
    logic            ref_req;
    logic            ref_urgent;
    logic            ref_busy;
    logic            ack_acc;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q    <= StIdle;
            int_cnt_q  <= '0;
            rfc_cnt_q  <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            int_cnt_q  <= int_cnt_d;
            rfc_cnt_q  <= rfc_cnt_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    // Interval counter only runs while init is complete; dropping init_done restarts it.
    always_comb begin
        int_cnt_d = int_cnt_q;
        tick      = 1'b0;
        if (!bus.init_done) begin
            int_cnt_d = '0;
        end else if (int_cnt_q == IntLast) begin
            int_cnt_d = '0;
            tick      = 1'b1;
        end else begin
            int_cnt_d = int_cnt_q + 1'b1;
        end
    end

    // A tick and an accepted ack in the same cycle cancel out.
    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (tick && !ack_acc) begin
            if (pending_q == CapCnt) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + 4'd1;
            end
        end else if (ack_acc && !tick) begin
            pending_d = pending_q - 4'd1;
        end
    end

`ifdef DRAM_REFRESH_POSTPONE_EN
    localparam logic [3:0] UrgentCnt = 4'(MaxPostpone);
    assign at_limit = (pending_q >= UrgentCnt);
`else
    assign at_limit = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        rfc_cnt_d  = rfc_cnt_q;
        ref_req    = 1'b0;
        ref_urgent = 1'b0;
        ref_busy   = 1'b0;
        ack_acc    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pending_q != 4'd0) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                ref_urgent = at_limit;
                // Non-urgent requests wait for the banks to close.
                ref_req    = bus.bank_idle || at_limit;
                ack_acc    = bus.ref_ack && ref_req;
                if (ack_acc) begin
                    state_d   = StRfc;
                    rfc_cnt_d = '0;
                end
            end
            StRfc: begin
                ref_busy = 1'b1;
                if (rfc_cnt_q == RfcLast) begin
                    state_d = StIdle;
                end else begin
                    rfc_cnt_d = rfc_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.ref_req      = ref_req;
    assign bus.ref_urgent   = ref_urgent;
    assign bus.ref_busy     = ref_busy;
    assign bus.pending_cnt  = pending_q;
    assign bus.overflow_err = overflow_q;

endmodule

// File: tb/tb_dram_refresh_scheduler.sv
// Randomized scoreboard bench for dram_refresh_scheduler against a cycle-timeline reference model.
module tb_dram_refresh_scheduler;
    localparam int TREFI        = 250;
    localparam int TRFC         = 172;
    localparam int MAX_POSTPONE = 8;
`ifdef DRAM_REFRESH_POSTPONE_EN
    localparam int MP = MAX_POSTPONE;
`else
    localparam int MP = 0;
`endif
    localparam int CAP = MP + 1;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    dram_refresh_scheduler_if bus ();

    dram_refresh_scheduler #(
        .TREFI       (TREFI),
        .TRFC        (TRFC),
        .MAX_POSTPONE(MAX_POSTPONE)
    ) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit chk;
        bit req;
        bit urg;
        bit busy;
        int pend;
        bit ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: refresh debt as an integer, ticks from a run-length of init_done,
    // the tRFC blackout as an absolute cycle window.
    bit m_valid   = 0;
    int m_cyc     = 0;
    int m_run     = 0;
    int m_pend    = 0;
    bit m_ovf     = 0;
    bit m_req     = 0;
    int m_rfc_end = -1;

    task automatic model_step();
        exp_t e;
        bit   tick;
        bit   acc;
        bit   busy;
        int   pend_now;
        busy   = (m_cyc <= m_rfc_end);
        e.chk  = m_valid;
        e.pend = m_pend;
        e.ovf  = m_ovf;
        e.busy = busy;
        e.urg  = m_req && (m_pend >= MP);
        e.req  = m_req && (bus.bank_idle || e.urg);
        sb.push_back(e);
        if (!nRST) begin
            m_valid   = 1;
            m_run     = 0;
            m_pend    = 0;
            m_ovf     = 0;
            m_req     = 0;
            m_rfc_end = m_cyc;
            m_cyc++;
            return;
        end
        pend_now = m_pend;
        tick     = bus.init_done && ((m_run % TREFI) == TREFI - 1);
        m_run    = bus.init_done ? m_run + 1 : 0;
        acc      = bus.ref_ack && e.req;
        if (tick && !acc) begin
            if (m_pend == CAP) m_ovf = 1;
            else m_pend++;
        end else if (acc && !tick) begin
            m_pend--;
        end
        if (acc) m_rfc_end = m_cyc + TRFC;
        m_req = !acc && (m_req || (!busy && pend_now > 0));
        m_cyc++;
    endtask

    task automatic drive(input bit rst_n, input bit idone, input bit bidle, input bit ack);
        @(posedge CLK);
        #1;
        nRST          = rst_n;
        bus.init_done = idone;
        bus.bank_idle = bidle;
        bus.ref_ack   = ack;
        model_step();
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            if (mon_e.chk) begin
                chk("ref_req", {3'b0, bus.ref_req}, {3'b0, mon_e.req});
                chk("ref_urgent", {3'b0, bus.ref_urgent}, {3'b0, mon_e.urg});
                chk("ref_busy", {3'b0, bus.ref_busy}, {3'b0, mon_e.busy});
                chk("pending_cnt", bus.pending_cnt, 4'(mon_e.pend));
                chk("overflow_err", {3'b0, bus.overflow_err}, {3'b0, mon_e.ovf});
            end
        end
    end

    initial begin
        bus.init_done = 1'b0;
        bus.bank_idle = 1'b1;
        bus.ref_ack   = 1'b0;
        repeat (3) drive(0, 0, 1, 0);
        repeat (5) drive(1, 0, 1, 0);

        // First refresh: init at cycle 0, ack at cycle 253, then the full tRFC window.
        for (int i = 0; i < 450; i++) drive(1, 1, 1, (i == 253));

        // Banks held open and no acks: debt builds to the cap and overflows.
        for (int i = 0; i < 10 * TREFI + 20; i++) drive(1, 1, 0, 0);

        // Busy traffic: frequent acks, occasional init_done drops and resets.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 1499) != 0), ($urandom_range(0, 99) != 0),
                  $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
        end

        // Sparse acks with mostly open banks: debt hovers mid-range, ticks meet acks.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 1999) != 0), 1'b1,
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 59) == 0));
        end

        @(negedge CLK);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dram_refresh_scheduler.md
# dram_refresh_scheduler

Tracks the DRAM refresh interval and owes refresh commands to the DRAM command controller. It sits directly upstream of the command FSM's REFRESH/REFRESHING states. It counts tREFI periods once initialization is complete and accumulates postponed-refresh debt. It raises a refresh request, normal or urgent, and then enforces the tRFC blackout after each issued REFRESH_CMD.

## Interface
- TREFI, default 250, refresh interval in cycles (matches package tREFI)
- TRFC, default 172, refresh cycle time in cycles (matches package tRFC)
- MAX_POSTPONE, default 8, maximum postponed refreshes before a request becomes urgent
- CLK  in  1  system clock; all logic on the rising edge
- nRST  in  1  synchronous, active-low reset
- init_done  in  1  init sequence finished (controller reached IDLE); enables interval counting
- bank_idle  in  1  all banks precharged, controller idle
- ref_ack  in  1  controller issued REFRESH_CMD this cycle
- ref_req  out  1  refresh requested
- ref_urgent  out  1  debt at limit; controller must precharge-all and refresh next
- ref_busy  out  1  inside the tRFC window; no commands allowed
- pending_cnt  out  4  outstanding refreshes owed
- overflow_err  out  1  sticky; an interval elapsed with debt already at its cap

## Operation
- Interval counter, width $clog2(TREFI):
  - Held at 0 while init_done=0.
  - Otherwise increments each cycle. At TREFI-1 it wraps to 0 and generates a one-cycle tick.
- pending_cnt update, in priority order:
  - tick and accepted ack: unchanged.
  - tick only: +1, saturating at CAP = MAX_POSTPONE+1.
  - accepted ack only: -1.
- A tick with pending_cnt == CAP and no accepted ack sets overflow_err. The count stays at CAP.
- FSM states:
  - IDLE: go to REQ when pending_cnt > 0.
  - REQ: an accepted ack moves to RFC and loads the tRFC counter with 0.
  - RFC: ref_busy=1. The counter increments; at TRFC-1 the FSM goes to IDLE.
- ref_urgent = (state==REQ) && pending_cnt >= MAX_POSTPONE.
- ref_req = (state==REQ) && (bank_idle || ref_urgent). A non-urgent request is withheld while banks are open.
- An ack is accepted only when ref_req=1. An ack in IDLE, in RFC, or while ref_req=0 is ignored with no state change.
- overflow_err clears only on reset.
- init_done falling mid-operation:
  - The interval counter returns to 0 and holds.
  - pending_cnt and the FSM continue; an in-progress RFC completes.

## Timing
- Reset values: ref_req=0, ref_urgent=0, ref_busy=0, pending_cnt=0, overflow_err=0. State is IDLE; both counters are 0.
- First tick: cycle TREFI-1 counted from the first cycle sampled with init_done=1. pending_cnt=1 is visible on the following cycle, and the FSM enters REQ one cycle after that.
- ref_req, ref_urgent and ref_busy decode combinationally from registered state and inputs. Each output is valid in the same cycle as the state change.
- After an accepted ack, ref_busy is high for exactly TRFC cycles starting the next cycle.
- Then IDLE for 1 cycle; REQ is re-entered on the following cycle if debt remains.
- Minimum spacing between two accepted acks: TRFC+2 cycles.

## Configuration
- DRAM_REFRESH_POSTPONE_EN defined: postponement as above (CAP = MAX_POSTPONE+1; urgent at pending_cnt ≥ MAX_POSTPONE).
- DRAM_REFRESH_POSTPONE_EN undefined: MAX_POSTPONE is treated as 0.
  - CAP = 1, so every request is urgent and ref_req ignores bank_idle.
  - A tick while pending_cnt == 1 and unacked sets overflow_err.

## Test plan
- Reset, then init_done=1 at cycle 0 with bank_idle=1 → pending_cnt=1 at cycle 250, ref_req=1 at cycle 251; ref_urgent=0 under DRAM_REFRESH_POSTPONE_EN.
- In the previous case, ack at cycle 253 → pending_cnt=0 at cycle 254; ref_busy high cycles 254–425; IDLE at 426; ref_req stays 0.
- bank_idle=0 and never ack for 8 intervals (MAX_POSTPONE=8) → ref_req=0 through 7 owed; at pending_cnt=8, ref_urgent=1 and ref_req=1 despite bank_idle=0.
- Keep withholding the ack: pending reaches 9 after the 9th interval; the 10th tick sets overflow_err=1 and pending_cnt stays 9; overflow_err persists after later acks until nRST=0.
- Ack coincident with a tick while pending_cnt=3 → pending_cnt stays 3 and the FSM enters RFC; ack pulsed during RFC → ignored, pending unchanged.
- nRST=0 for one cycle mid-RFC with pending_cnt=2 → next cycle all outputs 0, state IDLE, counters 0; no request until 250 cycles of init_done=1.
